// File: rtl/dct_pkg.sv
// Shared definitions for the 2D DCT-II datapath: size codes, array bound,
// size decoding helper and the transpose-buffer cycle classification.
package dct_pkg;

  localparam logic [1:0] SZ4  = 2'd0;
  localparam logic [1:0] SZ8  = 2'd1;
  localparam logic [1:0] SZ16 = 2'd2;
  localparam logic [1:0] SZ32 = 2'd3;

  localparam int MAXN = 32;

  typedef enum logic [2:0] {
    CYC_IDLE    = 3'd0,
    CYC_FILL    = 3'd1,
    CYC_DRAIN   = 3'd2,
    CYC_STREAM  = 3'd3,
    CYC_ILLEGAL = 3'd4
  } cyc_e;

  function automatic logic [5:0] size_len(input logic [1:0] code);
    return 6'd4 << code;
  endfunction

endpackage

// File: rtl/transpose_buffer_if.sv
// Strobe, data and status bundle between the transform control FSM and the
// transpose buffer.
interface transpose_buffer_if #(
  parameter int W    = 16,
  parameter int MAXN = 32
);
  logic                enable;
  logic                read;
  logic                write;
  logic                direction;
  logic [1:0]          N;
  logic [MAXN*W-1:0]   din;
  logic [MAXN*W-1:0]   dout;
  logic                dout_valid;
  logic [1:0]          dout_size;
  logic                full;
  logic                err;

  modport master (
    output enable, read, write, direction, N, din,
    input  dout, dout_valid, dout_size, full, err
  );

  modport slave (
    input  enable, read, write, direction, N, din,
    output dout, dout_valid, dout_size, full, err
  );
endinterface

// File: rtl/decode_size.sv
// Size-code decoder: transform length plus per-lane active and last-lane masks.
module decode_size #(
  parameter int MAXN = 32
) (
  input  logic [1:0]      code_i,
  output logic [5:0]      len_o,
  output logic [MAXN-1:0] act_o,
  output logic [MAXN-1:0] last_o
);
  import dct_pkg::*;

  // Thermometer (lane < T) and one-hot (lane == T-1) masks.
  always_comb begin
    len_o  = size_len(code_i);
    act_o  = '0;
    last_o = '0;
    for (int k = 0; k < MAXN; k++) begin
      act_o[k]  = (6'(k) < len_o);
      last_o[k] = ((6'(k) + 6'd1) == len_o);
    end
  end
endmodule

// File: rtl/transpose_buffer.sv
// Shift-register transpose memory: vectors enter along one axis and leave
// along the orthogonal axis, so each pass emits the transpose of the last block.
module transpose_buffer #(
  parameter int W    = 16,
  parameter int MAXN = 32
) (
  input  logic               clk,
  input  logic               reset,
  transpose_buffer_if.slave  bus
);
  import dct_pkg::*;

  logic [W-1:0]      mat_q [MAXN][MAXN];
  logic [W-1:0]      mat_d [MAXN][MAXN];
  logic [W-1:0]      ins_lane_s [MAXN];

  logic              stored_valid_q, stored_valid_d;
  logic              stored_dir_q, stored_dir_d;
  logic [1:0]        stored_code_q, stored_code_d;
  logic [5:0]        wcnt_q, wcnt_d;
  logic [5:0]        rcnt_q, rcnt_d;
  logic [MAXN*W-1:0] dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic [1:0]        dout_size_q, dout_size_d;
  logic              full_q, full_d;
  logic              err_q, err_d;

  logic [5:0]        tw_len_s, tr_len_s;
  logic [MAXN-1:0]   tw_act_s, tw_last_s, tr_act_s, tr_last_s;
  logic [MAXN-1:0]   act_s, last_s;
  logic              rd_s, wr_s, drain_legal_s;
  logic              shift_en_s, ins_en_s, emit_s, wr_done_s, rd_done_s;
  cyc_e              cyc_s;

  decode_size #(.MAXN(MAXN)) u_dec_tw (
    .code_i (bus.N),
    .len_o  (tw_len_s),
    .act_o  (tw_act_s),
    .last_o (tw_last_s)
  );

  decode_size #(.MAXN(MAXN)) u_dec_tr (
    .code_i (stored_code_q),
    .len_o  (tr_len_s),
    .act_o  (tr_act_s),
    .last_o (tr_last_s)
  );

  assign rd_s          = bus.enable & bus.read;
  assign wr_s          = bus.enable & bus.write;
  assign drain_legal_s = stored_valid_q & (bus.direction != stored_dir_q);

  // Classify the current cycle against the stored-block state.
  always_comb begin
    cyc_s = CYC_IDLE;
    case ({rd_s, wr_s})
      2'b00:   cyc_s = CYC_IDLE;
      2'b01:   cyc_s = stored_valid_q ? CYC_ILLEGAL : CYC_FILL;
      2'b10:   cyc_s = drain_legal_s ? CYC_DRAIN : CYC_ILLEGAL;
      2'b11:   cyc_s = (drain_legal_s && (bus.N == stored_code_q)) ? CYC_STREAM : CYC_ILLEGAL;
      default: cyc_s = CYC_ILLEGAL;
    endcase
  end

  assign ins_en_s   = (cyc_s == CYC_FILL) || (cyc_s == CYC_STREAM);
  assign emit_s     = (cyc_s == CYC_DRAIN) || (cyc_s == CYC_STREAM);
  assign shift_en_s = ins_en_s || emit_s;
  // Write cycles shift over the incoming size; read-only cycles over the stored size.
  assign act_s      = ins_en_s ? tw_act_s  : tr_act_s;
  assign last_s     = ins_en_s ? tw_last_s : tr_last_s;
  assign wr_done_s  = ins_en_s && ((wcnt_q + 6'd1) == tw_len_s);
  assign rd_done_s  = emit_s && ((rcnt_q + 6'd1) == tr_len_s);

  // Insertion lanes: incoming data on write cycles, zero on read-only drains.
  always_comb begin
    for (int i = 0; i < MAXN; i++) begin
      ins_lane_s[i] = ins_en_s ? bus.din[i*W +: W] : '0;
    end
  end

  for (genvar r = 0; r < MAXN; r++) begin : g_row
    for (genvar c = 0; c < MAXN; c++) begin : g_col
      logic [W-1:0] right_s, below_s, nbr_s, ins_s;
      logic         cell_en_s, edge_s;

      if (c < MAXN-1) begin : g_right
        assign right_s = mat_q[r][c+1];
      end else begin : g_right_end
        assign right_s = '0;
      end

      if (r < MAXN-1) begin : g_below
        assign below_s = mat_q[r+1][c];
      end else begin : g_below_end
        assign below_s = '0;
      end

      assign cell_en_s   = shift_en_s & act_s[r] & act_s[c];
      assign edge_s      = bus.direction ? last_s[r] : last_s[c];
      assign nbr_s       = bus.direction ? below_s : right_s;
      assign ins_s       = bus.direction ? ins_lane_s[c] : ins_lane_s[r];
      assign mat_d[r][c] = !cell_en_s ? mat_q[r][c] : (edge_s ? ins_s : nbr_s);
    end
  end

  // Next-state for counters, stored-block descriptor and registered outputs.
  always_comb begin
    wcnt_d         = wcnt_q;
    rcnt_d         = rcnt_q;
    stored_valid_d = stored_valid_q;
    stored_dir_d   = stored_dir_q;
    stored_code_d  = stored_code_q;
    dout_d         = dout_q;
    dout_size_d    = dout_size_q;

    if (ins_en_s) begin
      wcnt_d = wr_done_s ? 6'd0 : (wcnt_q + 6'd1);
    end else begin
      wcnt_d = wcnt_q;
    end

    if (emit_s) begin
      rcnt_d      = rd_done_s ? 6'd0 : (rcnt_q + 6'd1);
      dout_size_d = stored_code_q;
      for (int i = 0; i < MAXN; i++) begin
        dout_d[i*W +: W] = tr_act_s[i] ? (bus.direction ? mat_q[0][i] : mat_q[i][0]) : '0;
      end
    end else begin
      rcnt_d = rcnt_q;
    end

    // A completed write block takes precedence: in streaming it replaces the drained one.
    if (wr_done_s) begin
      stored_valid_d = 1'b1;
      stored_dir_d   = bus.direction;
      stored_code_d  = bus.N;
    end else if (rd_done_s) begin
      stored_valid_d = 1'b0;
    end else begin
      stored_valid_d = stored_valid_q;
    end

    dout_valid_d = emit_s;
    full_d       = stored_valid_d;
    err_d        = err_q | (cyc_s == CYC_ILLEGAL);
  end

  // Coefficient array.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < MAXN; r++) begin
        for (int c = 0; c < MAXN; c++) begin
          mat_q[r][c] <= '0;
        end
      end
    end else begin
      for (int r = 0; r < MAXN; r++) begin
        for (int c = 0; c < MAXN; c++) begin
          mat_q[r][c] <= mat_d[r][c];
        end
      end
    end
  end

  // Control state and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt_q         <= 6'd0;
      rcnt_q         <= 6'd0;
      stored_valid_q <= 1'b0;
      stored_dir_q   <= 1'b0;
      stored_code_q  <= 2'd0;
      dout_q         <= '0;
      dout_valid_q   <= 1'b0;
      dout_size_q    <= 2'd0;
      full_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      wcnt_q         <= wcnt_d;
      rcnt_q         <= rcnt_d;
      stored_valid_q <= stored_valid_d;
      stored_dir_q   <= stored_dir_d;
      stored_code_q  <= stored_code_d;
      dout_q         <= dout_d;
      dout_valid_q   <= dout_valid_d;
      dout_size_q    <= dout_size_d;
      full_q         <= full_d;
      err_q          <= err_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.dout_size  = dout_size_q;
  assign bus.full       = full_q;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_transpose_buffer.sv
// Directed bench for transpose_buffer: expected transposed vectors go into a
// queue that a negedge monitor pops whenever dout_valid is high.
module tb_transpose_buffer;
  localparam int W    = 16;
  localparam int MAXN = 32;
  localparam int VW   = MAXN*W;

  typedef struct {
    logic [VW-1:0] vec;
    logic [1:0]    size;
  } exp_t;

  logic clk;
  logic reset;
  exp_t exp_q[$];
  int   checks;
  int   failures;

  transpose_buffer_if #(.W(W), .MAXN(MAXN)) bus ();

  transpose_buffer #(.W(W), .MAXN(MAXN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lane i of the k-th written vector; lanes beyond the size carry junk.
  function automatic logic [VW-1:0] wr_vec(input int base, input int stride, input int k, input logic [1:0] code);
    logic [VW-1:0] v;
    int t;
    t = 4 << code;
    for (int i = 0; i < MAXN; i++) begin
      v[i*W +: W] = (i < t) ? 16'(base + k*stride + i) : 16'h7A5A;
    end
    return v;
  endfunction

  // j-th emitted vector of the transpose: lane i is lane j of written vector i.
  function automatic logic [VW-1:0] tr_vec(input int base, input int stride, input int j, input logic [1:0] code);
    logic [VW-1:0] v;
    int t;
    t = 4 << code;
    for (int i = 0; i < MAXN; i++) begin
      v[i*W +: W] = (i < t) ? 16'(base + i*stride + j) : 16'h0000;
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic cyc(input logic en, input logic rd, input logic wr, input logic dir,
                     input logic [1:0] n, input logic [VW-1:0] d);
    bus.enable    = en;
    bus.read      = rd;
    bus.write     = wr;
    bus.direction = dir;
    bus.N         = n;
    bus.din       = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, '0);
  endtask

  task automatic fill(input int base, input int stride, input logic [1:0] code, input logic dir, input int cnt);
    for (int k = 0; k < cnt; k++) cyc(1'b1, 1'b0, 1'b1, dir, code, wr_vec(base, stride, k, code));
  endtask

  task automatic stream(input int base, input int stride, input logic [1:0] code, input logic dir, inout int vcnt);
    for (int k = 0; k < (4 << code); k++) begin
      cyc(1'b1, 1'b1, 1'b1, dir, code, wr_vec(base, stride, k, code));
      if (bus.dout_valid === 1'b1) vcnt++;
    end
  endtask

  task automatic drain(input int cnt, input logic dir);
    repeat (cnt) cyc(1'b1, 1'b1, 1'b0, dir, 2'd0, '0);
  endtask

  task automatic push_block(input int base, input int stride, input logic [1:0] code);
    exp_t e;
    for (int j = 0; j < (4 << code); j++) begin
      e.vec  = tr_vec(base, stride, j, code);
      e.size = code;
      exp_q.push_back(e);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(1);
  endtask

  // Scoreboard monitor: every emitted vector must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bus.dout_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_emit dout=%0h size=%0d", bus.dout, bus.dout_size);
      end else begin
        e = exp_q.pop_front();
        if (bus.dout !== e.vec || bus.dout_size !== e.size) begin
          failures++;
          $display("FAIL dout got=%0h size=%0d exp=%0h size=%0d", bus.dout, bus.dout_size, e.vec, e.size);
        end
      end
    end
  end

  initial begin
    int vcnt;
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus.enable = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
    bus.direction = 1'b0; bus.N = 2'd0; bus.din = '0;
    idle(2);
    chk("rst_dout", bus.dout, '0);
    chk("rst_valid", VW'(bus.dout_valid), '0);
    chk("rst_size", VW'(bus.dout_size), '0);
    chk("rst_full", VW'(bus.full), '0);
    chk("rst_err", VW'(bus.err), '0);
    reset = 1'b0;
    idle(1);

    // Size 4: fill columns in direction 0, drain in direction 1.
    fill(0, 16, dct_pkg::SZ4, 1'b0, 4);
    chk("t1_full_after_fill", VW'(bus.full), VW'(1));
    push_block(0, 16, dct_pkg::SZ4);
    drain(3, 1'b1);
    chk("t1_full_after_3", VW'(bus.full), VW'(1));
    drain(1, 1'b1);
    chk("t1_full_after_4", VW'(bus.full), '0);
    idle(2);

    // Size 32 streaming, three blocks with alternating direction.
    vcnt = 0;
    fill(1000, 32, dct_pkg::SZ32, 1'b0, 32);
    push_block(1000, 32, dct_pkg::SZ32);
    stream(2100, 32, dct_pkg::SZ32, 1'b1, vcnt);
    push_block(2100, 32, dct_pkg::SZ32);
    stream(3200, 32, dct_pkg::SZ32, 1'b0, vcnt);
    chk("t2_stream_valid_cycles", VW'(vcnt), VW'(64));
    chk("t2_full_mid", VW'(bus.full), VW'(1));
    push_block(3200, 32, dct_pkg::SZ32);
    drain(32, 1'b1);
    chk("t2_full_end", VW'(bus.full), '0);
    chk("t2_err", VW'(bus.err), '0);
    idle(2);

    // Mismatched-size stream is rejected; block survives and drains intact.
    fill(2000, 8, dct_pkg::SZ8, 1'b0, 8);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, dct_pkg::SZ4, wr_vec(2500, 4, 0, dct_pkg::SZ4));
    chk("t3_err", VW'(bus.err), VW'(1));
    chk("t3_no_valid", VW'(bus.dout_valid), '0);
    push_block(2000, 8, dct_pkg::SZ8);
    drain(8, 1'b1);
    chk("t3_full_drained", VW'(bus.full), '0);
    fill(3000, 4, dct_pkg::SZ4, 1'b0, 4);
    chk("t3_fill4_full", VW'(bus.full), VW'(1));
    push_block(3000, 4, dct_pkg::SZ4);
    drain(4, 1'b1);
    idle(2);

    // Same-direction drain and write-while-full leave the matrix untouched.
    do_reset();
    chk("t4_err_cleared", VW'(bus.err), '0);
    fill(100, 10, dct_pkg::SZ8, 1'b1, 8);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 2'd0, '0);
    chk("t4_err_samedir", VW'(bus.err), VW'(1));
    chk("t4_no_valid", VW'(bus.dout_valid), '0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, dct_pkg::SZ8, wr_vec(900, 8, 0, dct_pkg::SZ8));
    chk("t4_full_kept", VW'(bus.full), VW'(1));
    push_block(100, 10, dct_pkg::SZ8);
    drain(8, 1'b0);
    idle(1);

    // Reset mid-fill, then a fresh size-16 pass.
    fill(700, 16, dct_pkg::SZ16, 1'b0, 5);
    reset = 1'b1;
    #1;
    chk("t5_async_dout", bus.dout, '0);
    chk("t5_async_err", VW'(bus.err), '0);
    idle(1);
    chk("t5_dout", bus.dout, '0);
    chk("t5_valid", VW'(bus.dout_valid), '0);
    chk("t5_size", VW'(bus.dout_size), '0);
    chk("t5_full", VW'(bus.full), '0);
    chk("t5_err", VW'(bus.err), '0);
    reset = 1'b0;
    idle(1);
    fill(500, 16, dct_pkg::SZ16, 1'b1, 16);
    chk("t5_full_fresh", VW'(bus.full), VW'(1));
    push_block(500, 16, dct_pkg::SZ16);
    drain(16, 1'b0);
    idle(1);

    // Enable low mid-drain freezes the block.
    fill(50, 8, dct_pkg::SZ8, 1'b0, 8);
    push_block(50, 8, dct_pkg::SZ8);
    drain(3, 1'b1);
    for (int h = 0; h < 3; h++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 2'd0, '0);
      chk("t6_hold_valid", VW'(bus.dout_valid), '0);
    end
    drain(5, 1'b1);
    idle(3);
    chk("end_queue_empty", VW'(exp_q.size()), '0);
    chk("end_err", VW'(bus.err), '0);
    chk("end_full", VW'(bus.full), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
